mul_div_unit: RTL and testbench

//  Iterative RV32M multiply/divide unit in the EX stage. Result feeds one input of the
//  32-bit 4:1 writeback-select mux. Accepts one operation per START, computes over multiple

---
 rtl/mul_div_unit_pkg.sv | 24 ++
 rtl/mdu_sign_conditioner.sv | 39 +++
 rtl/mul_div_unit.sv | 189 ++++++++++++++++++
 tb/tb_mul_div_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
// Holds funct3 opcodes, FSM state encodings and the iteration count.
// Imported by the top level and by the sign conditioner.
package mul_div_unit_pkg;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIN  = 2'b10
  } state_t;

  // One iteration per result bit.
  localparam int ITER_COUNT = 32;

endpackage

// File: rtl/mdu_sign_conditioner.sv
// Combinational sign handling for the multiply/divide unit.
// Latency: zero cycles (purely combinational).
// Backpressure: none; outputs follow inputs directly.
module mdu_sign_conditioner
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]         funct3,
  input  logic [WIDTH-1:0]   op1,
  input  logic [WIDTH-1:0]   op2,
  output logic [WIDTH-1:0]   mag1,
  output logic [WIDTH-1:0]   mag2,
  output logic               sign1,
  output logic               sign2,
  input  logic [2*WIDTH-1:0] neg_in,
  input  logic               neg_en,
  output logic [2*WIDTH-1:0] neg_out
);

  logic signed1;
  logic signed2;

  // Decide operand signedness from funct3, then strip signs to unsigned magnitudes.
  always_comb begin
    signed1 = !((funct3 == MDU_MULHU) || (funct3 == MDU_DIVU) || (funct3 == MDU_REMU));
    signed2 = signed1 && (funct3 != MDU_MULHSU);
    sign1   = signed1 && op1[WIDTH-1];
    sign2   = signed2 && op2[WIDTH-1];
    mag1    = sign1 ? -op1 : op1;
    mag2    = sign2 ? -op2 : op2;
  end

  // Two's-complement negate of the raw 64-bit result when the final sign is negative.
  always_comb begin
    neg_out = neg_en ? -neg_in : neg_in;
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide.
// Latency: 34 cycles START->DONE normally, 2 cycles for divide-by-zero/overflow.
// Backpressure: START is ignored while BUSY; the caller stalls until DONE.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 6
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [2:0]       FUNCT3,
  input  logic [WIDTH-1:0] OPERAND1,
  input  logic [WIDTH-1:0] OPERAND2,
  output logic [WIDTH-1:0] RESULT,
  output logic             BUSY,
  output logic             DONE
);

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d;      // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]       opb_q, opb_d;      // multiplicand or divisor magnitude
  logic [2:0]             op_q, op_d;
  logic                   res_neg_q, res_neg_d;
  logic                   special_q, special_d;
  logic [WIDTH-1:0]       result_q, result_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [WIDTH-1:0]       mag1, mag2;
  logic                   sign1, sign2;
  logic [2*WIDTH-1:0]     neg_in, neg_out;
  logic                   neg_en;
  logic [WIDTH:0]         mul_sum;
  logic [WIDTH+1:0]       div_diff;
  logic                   div_zero, div_ovf;

  mdu_sign_conditioner #(.WIDTH(WIDTH)) u_sign (
    .funct3  (FUNCT3),
    .op1     (OPERAND1),
    .op2     (OPERAND2),
    .mag1    (mag1),
    .mag2    (mag2),
    .sign1   (sign1),
    .sign2   (sign2),
    .neg_in  (neg_in),
    .neg_en  (neg_en),
    .neg_out (neg_out)
  );

  // One step of each algorithm: conditional add of the multiplicand, trial subtract of the divisor.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    div_diff = {1'b0, acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {2'b00, opb_q};
  end

  // Flag the divide cases whose result is fixed by the ISA and needs no iteration.
  always_comb begin
    div_zero = FUNCT3[2] && (OPERAND2 == '0);
    div_ovf  = FUNCT3[2] && !FUNCT3[0]
               && (OPERAND1 == {1'b1, {(WIDTH-1){1'b0}}}) && (OPERAND2 == '1);
  end

  // Choose the raw result half to sign-correct; special results bypass the negate.
  always_comb begin
    if (!op_q[2]) begin
      neg_in = acc_q;
    end else if (op_q[1]) begin
      neg_in = {{WIDTH{1'b0}}, acc_q[2*WIDTH-1:WIDTH]};
    end else begin
      neg_in = {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
    end
    neg_en = res_neg_q && !special_q;
  end

  // FSM next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    op_d      = op_q;
    res_neg_d = res_neg_q;
    special_d = special_q;
    result_d  = result_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          op_d      = FUNCT3;
          busy_d    = 1'b1;
          cnt_d     = '0;
          special_d = 1'b0;
          res_neg_d = (FUNCT3[2] && FUNCT3[1]) ? sign1 : (sign1 ^ sign2);
          if (FUNCT3[2]) begin
            opb_d = mag2;
            acc_d = {{WIDTH{1'b0}}, mag1};
          end else begin
            opb_d = mag1;
            acc_d = {{WIDTH{1'b0}}, mag2};
          end
          if (div_zero) begin
            special_d = 1'b1;
            acc_d     = {{WIDTH{1'b0}}, (FUNCT3[1] ? OPERAND1 : {WIDTH{1'b1}})};
            state_d   = S_FIN;
          end else if (div_ovf) begin
            special_d = 1'b1;
            acc_d     = {{WIDTH{1'b0}}, (FUNCT3[1] ? {WIDTH{1'b0}} : OPERAND1)};
            state_d   = S_FIN;
          end else begin
            state_d   = S_CALC;
          end
        end
      end

      S_CALC: begin
        if (op_q[2]) begin
          if (div_diff[WIDTH+1]) begin
            acc_d = {acc_q[2*WIDTH-2:WIDTH-1], acc_q[WIDTH-2:0], 1'b0};
          end else begin
            acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          end
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_WIDTH'(ITER_COUNT - 1)) begin
          cnt_d   = '0;
          state_d = S_FIN;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end

      S_FIN: begin
        if (special_q) begin
          result_d = acc_q[WIDTH-1:0];
        end else if ((op_q == MDU_MUL) || op_q[2]) begin
          result_d = neg_out[WIDTH-1:0];
        end else begin
          result_d = neg_out[2*WIDTH-1:WIDTH];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers; reset aborts any operation in flight.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      op_q      <= '0;
      res_neg_q <= 1'b0;
      special_q <= 1'b0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      op_q      <= op_d;
      res_neg_q <= res_neg_d;
      special_q <= special_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign RESULT = result_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Testbench for mul_div_unit: directed vectors plus a cycle-level reference model.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op1, op2;
  logic [31:0] result;
  logic        busy, done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bit          m_active = 1'b0;
  int          m_done   = 0;
  logic [31:0] m_res    = '0;
  logic [31:0] m_hold   = '0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(32), .CNT_WIDTH(6)) dut (
    .CLK      (clk),
    .RESET    (rst),
    .START    (start),
    .FUNCT3   (funct3),
    .OPERAND1 (op1),
    .OPERAND2 (op2),
    .RESULT   (result),
    .BUSY     (busy),
    .DONE     (done)
  );

  function automatic logic [31:0] model_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    int sa, sb;
    bit ovf;
    sa  = int'(a);
    sb  = int'(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'b000: begin ea = {{32{a[31]}}, a}; eb = {{32{b[31]}}, b}; p = ea * eb; return p[31:0]; end
      3'b001: begin ea = {{32{a[31]}}, a}; eb = {{32{b[31]}}, b}; p = ea * eb; return p[63:32]; end
      3'b010: begin ea = {{32{a[31]}}, a}; eb = {32'b0, b};       p = ea * eb; return p[63:32]; end
      3'b011: begin ea = {32'b0, a};       eb = {32'b0, b};       p = ea * eb; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 2;
    return 34;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model acceptance: START is taken at a rising edge only when no operation is outstanding.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst && start && (!m_active || cyc > m_done)) begin
      m_active = 1'b1;
      m_res    = model_res(funct3, op1, op2);
      m_done   = cyc + model_lat(funct3, op1, op2) - 1;
    end
  end

  // Every cycle: BUSY, DONE and the held RESULT must match the model.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_busy", {31'b0, busy}, 32'h0);
      chk("rst_done", {31'b0, done}, 32'h0);
      chk("rst_result", result, 32'h0);
    end else begin
      if (m_active && cyc == m_done) m_hold = m_res;
      chk("cyc_busy", {31'b0, busy}, {31'b0, (m_active && cyc < m_done)});
      chk("cyc_done", {31'b0, done}, {31'b0, (m_active && cyc == m_done)});
      chk("cyc_result", result, m_hold);
    end
  end

  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input int exp_busy);
    int lat, bcnt;
    chk({"model_", name}, model_res(f, a, b), exp);
    start = 1'b1; funct3 = f; op1 = a; op2 = b;
    lat = 0; bcnt = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
      if (lat == 1) begin
        start  = 1'b0;
        funct3 = 3'($urandom_range(7));
        op1    = $urandom;
        op2    = $urandom;
      end
    end while (!done && lat < 100);
    chk({"result_", name}, result, exp);
    chk({"latency_", name}, 32'(lat), 32'(exp_lat));
    if (exp_busy >= 0) chk({"busy_cycles_", name}, 32'(bcnt), 32'(exp_busy));
  endtask

  logic [2:0]  bf[4] = '{3'b000, 3'b101, 3'b011, 3'b110};
  logic [31:0] ba[4] = '{32'd3, 32'd1000, 32'h8000_0000, 32'hFFFF_FF9C};
  logic [31:0] bb[4] = '{32'd5, 32'd9, 32'd4, 32'd7};
  logic [31:0] be[4] = '{32'd15, 32'd111, 32'd2, 32'hFFFF_FFFE};

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; funct3 = '0; op1 = '0; op2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op("mul_7_m3",    3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 33);
    run_op("mulhu_m1",    3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 33);
    run_op("mulh_m1",     3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 34, -1);
    run_op("mulhsu_m1_2", 3'b010, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 34, -1);
    run_op("mulh_min",    3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34, -1);
    run_op("div_m20_3",   3'b100, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA, 34, 33);
    run_op("rem_m20_3",   3'b110, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE, 34, -1);
    run_op("divu_100_7",  3'b101, 32'd100,        32'd7,         32'd14,        34, -1);
    run_op("remu_100_7",  3'b111, 32'd100,        32'd7,         32'd2,         34, -1);
    run_op("div_7_m2",    3'b100, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, -1);
    run_op("rem_7_m2",    3'b110, 32'd7,          32'hFFFF_FFFE, 32'd1,         34, -1);
    run_op("div_5_0",     3'b100, 32'd5,          32'd0,         32'hFFFF_FFFF, 2, 1);
    run_op("remu_5_0",    3'b111, 32'd5,          32'd0,         32'd5,         2, 1);
    run_op("div_ovf",     3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2, 1);
    run_op("rem_ovf",     3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         2, 1);

    // START held high; each DONE cycle presents the next operation.
    start = 1'b1; funct3 = bf[0]; op1 = ba[0]; op2 = bb[0];
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!done && n < 100);
      chk("b2b_spacing", 32'(n), 32'd34);
      chk("b2b_result", result, be[k]);
      if (k < 3) begin funct3 = bf[k+1]; op1 = ba[k+1]; op2 = bb[k+1]; end
      else start = 1'b0;
    end

    // START pulse while busy must not disturb the operation in flight.
    start = 1'b1; funct3 = 3'b101; op1 = 32'd1000; op2 = 32'd7;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; funct3 = 3'b000; op1 = 32'd2; op2 = 32'd2;
    @(negedge clk); start = 1'b0;
    n = 6;
    while (!done && n < 100) begin @(negedge clk); n++; end
    chk("midcalc_result", result, 32'd142);
    chk("midcalc_latency", 32'(n), 32'd34);

    // Asynchronous reset in the middle of a divide.
    start = 1'b1; funct3 = 3'b100; op1 = 32'h7FFF_FFFF; op2 = 32'd3;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    rst = 1'b1;
    m_active = 1'b0;
    m_hold   = '0;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("abort_done", {31'b0, done}, 32'h0);
    chk("abort_result", result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (40) begin @(negedge clk); if (done) n++; end
    chk("abort_no_done", 32'(n), 32'd0);
    run_op("mul_6_7", 3'b000, 32'd6, 32'd7, 32'd42, 34, 33);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
